// File: rtl/spi_bridge_pkg.sv
// Shared constants and types for the SPI-to-bus bridge: register indices,
// CTRL/STATUS bit positions and the bus FSM state encoding.
package spi_bridge_pkg;

   localparam logic [1:0] IDX_ADDR  = 2'd0;
   localparam logic [1:0] IDX_WDATA = 2'd1;
   localparam logic [1:0] IDX_CTRL  = 2'd2;
   localparam logic [1:0] IDX_RDATA = 2'd3;

   localparam int unsigned CTRL_START_BIT = 0;
   localparam int unsigned CTRL_WE_BIT    = 1;

   localparam int unsigned STAT_BUSY_BIT = 0;
   localparam int unsigned STAT_DONE_BIT = 1;
   localparam int unsigned STAT_ERR_BIT  = 2;

   typedef enum logic [1:0] {
      StIdle,
      StReq,
      StWaitRvalid
   } state_e;

   function automatic logic [31:0] pack_status(input logic busy, input logic done,
                                               input logic err);
      logic [31:0] status;
      status                = '0;
      status[STAT_BUSY_BIT] = busy;
      status[STAT_DONE_BIT] = done;
      status[STAT_ERR_BIT]  = err;
      return status;
   endfunction

endpackage

// File: rtl/spi_we_sync.sv
// Brings the sck-domain write strobe into clk domain and emits a single-cycle
// pulse per rising edge, however long the strobe stays high.
module spi_we_sync #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_we_async,
   output logic o_we_pulse
);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_prev;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_sync <= '0;
         r_prev <= 1'b0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], i_we_async};
         r_prev <= r_sync[SYNC_STAGES-1];
      end
   end

   assign o_we_pulse = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule

// File: rtl/spi_bus_bridge.sv
// Register file written from an SPI slave that launches single-word bus
// reads/writes through a req/gnt + rvalid handshake.
module spi_bus_bridge
   import spi_bridge_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [1:0]  spi_addr_i,
   input  logic [31:0] spi_wdata_i,
   input  logic        spi_we_i,
   output logic [31:0] spi_rdata_o,
   output logic        data_req_o,
   input  logic        data_gnt_i,
   output logic        data_we_o,
   output logic [3:0]  data_be_o,
   output logic [31:0] data_addr_o,
   output logic [31:0] data_wdata_o,
   input  logic        data_rvalid_i,
   input  logic [31:0] data_rdata_i
);

   logic w_we_pulse;

   state_e      r_state;
   logic [31:0] r_addr;
   logic [31:0] r_wdata;
   logic [31:0] r_rdata;
   logic        r_busy;
   logic        r_done;
   logic        r_err;
   logic        r_req;
   logic        r_we;
   logic [3:0]  r_be;

   spi_we_sync #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_we_sync (
      .i_clk      (clk_i),
      .i_rst      (rst_i),
      .i_we_async (spi_we_i),
      .o_we_pulse (w_we_pulse)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= StIdle;
         r_addr  <= '0;
         r_wdata <= '0;
         r_rdata <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
         r_req   <= 1'b0;
         r_we    <= 1'b0;
         r_be    <= 4'h0;
      end else begin
         // RDATA is read-only, so a write to it while busy is not a collision
         if (w_we_pulse && r_busy && (spi_addr_i != IDX_RDATA)) begin
            r_err <= 1'b1;
         end
         unique case (r_state)
            StIdle: begin
               if (w_we_pulse) begin
                  unique case (spi_addr_i)
                     IDX_ADDR:  r_addr  <= spi_wdata_i;
                     IDX_WDATA: r_wdata <= spi_wdata_i;
                     IDX_CTRL: begin
                        if (spi_wdata_i[CTRL_START_BIT]) begin
                           r_state <= StReq;
                           r_we    <= spi_wdata_i[CTRL_WE_BIT];
                           r_req   <= 1'b1;
                           r_be    <= 4'hF;
                           r_busy  <= 1'b1;
                           r_done  <= 1'b0;
                           r_err   <= 1'b0;
                        end
                     end
                     default: ;
                  endcase
               end
            end
            StReq: begin
               if (data_gnt_i) begin
                  r_req <= 1'b0;
                  if (r_we) begin
                     r_state <= StIdle;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                  end else begin
                     r_state <= StWaitRvalid;
                  end
               end
            end
            StWaitRvalid: begin
               if (data_rvalid_i) begin
                  r_rdata <= data_rdata_i;
                  r_state <= StIdle;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end
            end
            default: begin
               r_state <= StIdle;
               r_req   <= 1'b0;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   always_comb begin
      spi_rdata_o = '0;
      unique case (spi_addr_i)
         IDX_ADDR:  spi_rdata_o = r_addr;
         IDX_WDATA: spi_rdata_o = r_wdata;
         IDX_CTRL:  spi_rdata_o = pack_status(r_busy, r_done, r_err);
         IDX_RDATA: spi_rdata_o = r_rdata;
         default:   spi_rdata_o = '0;
      endcase
   end

   assign data_req_o   = r_req;
   assign data_we_o    = r_we;
   assign data_be_o    = r_be;
   assign data_addr_o  = r_addr;
   assign data_wdata_o = r_wdata;

endmodule

// File: tb/tb_spi_bus_bridge.sv
// Directed bench for spi_bus_bridge: scoreboard queues hold the expected bus
// transactions and read data, checked when the bridge produces them.
module tb_spi_bus_bridge;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic [1:0]  spi_addr_i;
   logic [31:0] spi_wdata_i;
   logic        spi_we_i;
   logic [31:0] spi_rdata_o;
   logic        data_req_o;
   logic        data_gnt_i;
   logic        data_we_o;
   logic [3:0]  data_be_o;
   logic [31:0] data_addr_o;
   logic [31:0] data_wdata_o;
   logic        data_rvalid_i;
   logic [31:0] data_rdata_i;

   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
   } txn_t;

   txn_t        exp_q[$];
   logic [31:0] rd_q[$];

   int n_assert = 0;
   int n_fail   = 0;

   spi_bus_bridge #(
      .SYNC_STAGES(2)
   ) dut (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .spi_addr_i    (spi_addr_i),
      .spi_wdata_i   (spi_wdata_i),
      .spi_we_i      (spi_we_i),
      .spi_rdata_o   (spi_rdata_o),
      .data_req_o    (data_req_o),
      .data_gnt_i    (data_gnt_i),
      .data_we_o     (data_we_o),
      .data_be_o     (data_be_o),
      .data_addr_o   (data_addr_o),
      .data_wdata_o  (data_wdata_o),
      .data_rvalid_i (data_rvalid_i),
      .data_rdata_i  (data_rdata_i)
   );

   always #5 clk_i = ~clk_i;

   task automatic tick();
      @(negedge clk_i);
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic spi_write(input logic [1:0] idx, input logic [31:0] d);
      spi_addr_i  = idx;
      spi_wdata_i = d;
      spi_we_i    = 1'b1;
      repeat (3) tick();
      spi_we_i = 1'b0;
      repeat (5) tick();
   endtask

   task automatic read_reg(input string tag, input logic [1:0] idx, input logic [31:0] exp);
      spi_addr_i = idx;
      #1;
      check(tag, spi_rdata_o, exp);
   endtask

   // Waits (bounded) for a request, then checks it against the scoreboard head.
   task automatic wait_req(input string tag);
      txn_t t;
      for (int i = 0; i < 20 && !data_req_o; i++) tick();
      check({tag, "_req_seen"}, {31'b0, data_req_o}, 32'd1);
      if (exp_q.size() == 0) begin
         check({tag, "_txn_queue"}, 32'd0, 32'd1);
      end else begin
         t = exp_q.pop_front();
         check({tag, "_we"}, {31'b0, data_we_o}, {31'b0, t.we});
         check({tag, "_addr"}, data_addr_o, t.addr);
         check({tag, "_wdata"}, data_wdata_o, t.wdata);
         check({tag, "_be"}, {28'b0, data_be_o}, 32'hF);
      end
   endtask

   task automatic grant();
      data_gnt_i = 1'b1;
      tick();
      data_gnt_i = 1'b0;
   endtask

   task automatic respond(input logic [31:0] d);
      data_rvalid_i = 1'b1;
      data_rdata_i  = d;
      rd_q.push_back(d);
      tick();
      data_rvalid_i = 1'b0;
      data_rdata_i  = 32'hBAD0_BAD0;
   endtask

   task automatic check_rdata(input string tag);
      if (rd_q.size() == 0) check({tag, "_rd_queue"}, 32'd0, 32'd1);
      else read_reg(tag, 2'd3, rd_q.pop_front());
   endtask

   initial begin
      int lat;
      rst_i         = 1'b1;
      spi_addr_i    = 2'd0;
      spi_wdata_i   = '0;
      spi_we_i      = 1'b0;
      data_gnt_i    = 1'b0;
      data_rvalid_i = 1'b0;
      data_rdata_i  = '0;
      repeat (3) tick();
      rst_i = 1'b0;

      check("rst_req", {31'b0, data_req_o}, 32'd0);
      check("rst_be", {28'b0, data_be_o}, 32'd0);
      check("rst_we", {31'b0, data_we_o}, 32'd0);
      read_reg("rst_addr", 2'd0, 32'd0);
      read_reg("rst_wdata", 2'd1, 32'd0);
      read_reg("rst_status", 2'd2, 32'd0);
      read_reg("rst_rdata", 2'd3, 32'd0);

      // Write path
      spi_write(2'd0, 32'h0000_1000);
      spi_write(2'd1, 32'hDEAD_BEEF);
      read_reg("wr_addr_reg", 2'd0, 32'h0000_1000);
      read_reg("wr_wdata_reg", 2'd1, 32'hDEAD_BEEF);
      exp_q.push_back('{we: 1'b1, addr: 32'h0000_1000, wdata: 32'hDEAD_BEEF});
      spi_write(2'd2, 32'h3);
      wait_req("wr");
      repeat (2) tick();
      check("wr_req_held", {31'b0, data_req_o}, 32'd1);
      check("wr_addr_held", data_addr_o, 32'h0000_1000);
      grant();
      check("wr_req_drop", {31'b0, data_req_o}, 32'd0);
      read_reg("wr_status", 2'd2, 32'h2);

      // Read path
      spi_write(2'd0, 32'h0000_2000);
      exp_q.push_back('{we: 1'b0, addr: 32'h0000_2000, wdata: 32'hDEAD_BEEF});
      spi_write(2'd2, 32'h1);
      wait_req("rd");
      tick();
      grant();
      read_reg("rd_status_busy", 2'd2, 32'h1);
      repeat (2) tick();
      respond(32'h1234_5678);
      check_rdata("rd_rdata");
      read_reg("rd_status", 2'd2, 32'h2);

      // CTRL with start=0 is a no-op
      spi_write(2'd2, 32'h2);
      check("nostart_req", {31'b0, data_req_o}, 32'd0);
      read_reg("nostart_status", 2'd2, 32'h2);

      // Busy collision
      exp_q.push_back('{we: 1'b0, addr: 32'h0000_2000, wdata: 32'hDEAD_BEEF});
      spi_write(2'd2, 32'h1);
      wait_req("col");
      grant();
      spi_write(2'd1, 32'hFFFF_FFFF);
      read_reg("col_wdata", 2'd1, 32'hDEAD_BEEF);
      read_reg("col_status_busy", 2'd2, 32'h5);
      respond(32'hCAFE_F00D);
      read_reg("col_status_done", 2'd2, 32'h6);
      check_rdata("col_rdata");

      // Stray handshakes in IDLE
      data_gnt_i    = 1'b1;
      data_rvalid_i = 1'b1;
      data_rdata_i  = 32'h0000_0055;
      repeat (3) tick();
      data_gnt_i    = 1'b0;
      data_rvalid_i = 1'b0;
      check("stray_req", {31'b0, data_req_o}, 32'd0);
      read_reg("stray_status", 2'd2, 32'h6);
      read_reg("stray_rdata", 2'd3, 32'hCAFE_F00D);
      read_reg("stray_addr", 2'd0, 32'h0000_2000);

      // Long strobe on ADDR: measure latency from the first sampling edge
      spi_addr_i  = 2'd0;
      spi_wdata_i = 32'h0000_3000;
      spi_we_i    = 1'b1;
      lat         = 0;
      for (int e = 1; e <= 10; e++) begin
         tick();
         if (lat == 0 && spi_rdata_o === 32'h0000_3000) lat = e;
      end
      spi_we_i = 1'b0;
      repeat (5) tick();
      check("long_latency", lat, 32'd3);
      read_reg("long_addr", 2'd0, 32'h0000_3000);

      // Long strobe on CTRL: a second event would flag err while busy
      exp_q.push_back('{we: 1'b1, addr: 32'h0000_3000, wdata: 32'hDEAD_BEEF});
      spi_addr_i  = 2'd2;
      spi_wdata_i = 32'h3;
      spi_we_i    = 1'b1;
      repeat (10) tick();
      spi_we_i = 1'b0;
      repeat (5) tick();
      read_reg("long_ctrl_status", 2'd2, 32'h1);
      wait_req("long");
      grant();
      read_reg("long_status_done", 2'd2, 32'h2);

      // Reset in WAIT_RVALID, then a stray rvalid
      exp_q.push_back('{we: 1'b0, addr: 32'h0000_3000, wdata: 32'hDEAD_BEEF});
      spi_write(2'd2, 32'h1);
      wait_req("rst_mid");
      grant();
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
      data_rvalid_i = 1'b1;
      data_rdata_i  = 32'h7777_7777;
      tick();
      data_rvalid_i = 1'b0;
      tick();
      check("rstm_req", {31'b0, data_req_o}, 32'd0);
      check("rstm_be", {28'b0, data_be_o}, 32'd0);
      check("rstm_bus_addr", data_addr_o, 32'd0);
      read_reg("rstm_status", 2'd2, 32'd0);
      read_reg("rstm_rdata", 2'd3, 32'd0);
      read_reg("rstm_addr", 2'd0, 32'd0);
      read_reg("rstm_wdata", 2'd1, 32'd0);

      check("txn_queue_empty", exp_q.size(), 32'd0);
      check("rd_queue_empty", rd_q.size(), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
